// File: rtl/cam_capture_stream.sv
// Camera capture: oversamples an async DVP-style bus, packs bytes into pixels, frames them and
// streams them out through a FWFT FIFO. Optional 2x2 decimation when CAM_DECIM_EN is defined.
module cam_capture_stream #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned PIX_BYTES  = 2,
   parameter int unsigned H_ACTIVE   = 640,
   parameter int unsigned V_ACTIVE   = 480,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                        clk_clk,
   input  logic                        reset_reset_n,
   input  logic                        cmos_pclk,
   input  logic                        cmos_href,
   input  logic                        cmos_vsync,
   input  logic [DATA_W-1:0]           cmos_db,
   input  logic                        enable,
   output logic [PIX_BYTES*DATA_W-1:0] out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        out_sop,
   output logic                        out_eop,
   output logic [15:0]                 frame_cnt,
   output logic                        overflow,
   output logic                        short_frame,
   input  logic                        clr_status
);

   localparam int unsigned PIX_W = PIX_BYTES * DATA_W;
   localparam int unsigned XW    = $clog2(H_ACTIVE + 1);
   localparam int unsigned YW    = $clog2(V_ACTIVE + 1);
   localparam int unsigned BW    = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
   localparam int unsigned AW    = $clog2(FIFO_DEPTH);
   localparam int unsigned EW    = PIX_W + 2;
   localparam int unsigned SW    = DATA_W + 3;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_WAIT   = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_DROP   = 2'd3;

   // Synchronisers: all camera lines share one delay so db stays aligned with the pclk edge.
   logic [SW-1:0] sync1_q, sync2_q;
   logic          pclk_prev_q, href_prev_q, vsync_prev_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         sync1_q      <= '0;
         sync2_q      <= '0;
         pclk_prev_q  <= 1'b0;
         href_prev_q  <= 1'b0;
         vsync_prev_q <= 1'b0;
      end else begin
         sync1_q      <= {cmos_pclk, cmos_href, cmos_vsync, cmos_db};
         sync2_q      <= sync1_q;
         pclk_prev_q  <= sync2_q[DATA_W+2];
         href_prev_q  <= sync2_q[DATA_W+1];
         vsync_prev_q <= sync2_q[DATA_W];
      end
   end

   logic              pclk_s, href_s, vsync_s;
   logic [DATA_W-1:0] db_s;
   logic              sample, href_fall, vs_rise, vs_fall;

   always_comb begin
      pclk_s    = sync2_q[DATA_W+2];
      href_s    = sync2_q[DATA_W+1];
      vsync_s   = sync2_q[DATA_W];
      db_s      = sync2_q[DATA_W-1:0];
      sample    = pclk_s & ~pclk_prev_q;
      href_fall = href_prev_q & ~href_s;
      vs_rise   = vsync_s & ~vsync_prev_q;
      vs_fall   = ~vsync_s & vsync_prev_q;
   end

   // Pixel packing: first byte received ends up in the MSBs.
   logic [PIX_W-1:0] pix_q, pix_d, pix_next;

   generate
      if (PIX_BYTES > 1) begin : g_shift
         assign pix_next = {pix_q[PIX_W-DATA_W-1:0], db_s};
      end else begin : g_noshift
         assign pix_next = db_s;
      end
   endgenerate

   logic [1:0]    state_q, state_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic [BW-1:0] byte_q, byte_d;
   logic          in_range, keep, is_sop, is_eop, byte_last;

   always_comb begin
      in_range  = (x_q < XW'(H_ACTIVE)) && (y_q < YW'(V_ACTIVE));
      is_sop    = (x_q == '0) && (y_q == '0);
      byte_last = (byte_q == BW'(PIX_BYTES - 1));
`ifdef CAM_DECIM_EN
      keep      = in_range && !x_q[0] && !y_q[0];
      is_eop    = (x_q == XW'(H_ACTIVE - 2)) && (y_q == YW'(V_ACTIVE - 2));
`else
      keep      = in_range;
      is_eop    = (x_q == XW'(H_ACTIVE - 1)) && (y_q == YW'(V_ACTIVE - 1));
`endif
   end

   // FIFO pointers carry an extra wrap bit to tell full from empty.
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, rd_ptr_q;
   logic          empty, full, pop, can_push, push_req, push_we;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      pop      = !empty && out_ready;
      can_push = !full || pop;
      push_we  = push_req && can_push;
   end

   logic ovf_set, short_set, frame_inc;

   always_comb begin
      state_d   = state_q;
      x_d       = x_q;
      y_d       = y_q;
      byte_d    = byte_q;
      pix_d     = pix_q;
      push_req  = 1'b0;
      ovf_set   = 1'b0;
      short_set = 1'b0;
      frame_inc = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (enable) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (vs_fall) begin
               state_d = ST_ACTIVE;
               x_d     = '0;
               y_d     = '0;
               byte_d  = '0;
            end
         end
         ST_ACTIVE: begin
            if (vs_rise) begin
               short_set = 1'b1;
               state_d   = enable ? ST_WAIT : ST_IDLE;
            end else if (href_fall) begin
               if (y_q < YW'(V_ACTIVE)) y_d = y_q + YW'(1);
               x_d    = '0;
               byte_d = '0;
            end else if (sample && href_s) begin
               pix_d = pix_next;
               if (byte_last) begin
                  byte_d = '0;
                  if (x_q < XW'(H_ACTIVE)) x_d = x_q + XW'(1);
                  if (keep) begin
                     push_req = 1'b1;
                     if (!can_push) begin
                        ovf_set = 1'b1;
                        state_d = ST_DROP;
                     end else if (is_eop) begin
                        frame_inc = 1'b1;
                        state_d   = enable ? ST_WAIT : ST_IDLE;
                     end
                  end
               end else begin
                  byte_d = byte_q + BW'(1);
               end
            end
         end
         ST_DROP: begin
            if (vs_fall) begin
               state_d = enable ? ST_ACTIVE : ST_IDLE;
               x_d     = '0;
               y_d     = '0;
               byte_d  = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   logic [15:0] frame_cnt_q;
   logic        overflow_q, short_q;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= ST_IDLE;
         x_q         <= '0;
         y_q         <= '0;
         byte_q      <= '0;
         pix_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         frame_cnt_q <= '0;
         overflow_q  <= 1'b0;
         short_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         byte_q      <= byte_d;
         pix_q       <= pix_d;
         if (push_we) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
         if (pop) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
         if (frame_inc) frame_cnt_q <= frame_cnt_q + 16'd1;
         // A new event in the same cycle as clr_status keeps the flag set.
         overflow_q  <= (overflow_q & ~clr_status) | ovf_set;
         short_q     <= (short_q & ~clr_status) | short_set;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (push_we) mem_q[wr_ptr_q[AW-1:0]] <= {is_sop, is_eop, pix_next};
   end

   logic [EW-1:0] head;

   always_comb begin
      head        = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
      out_valid   = !empty;
      out_data    = head[PIX_W-1:0];
      out_eop     = head[PIX_W];
      out_sop     = head[PIX_W+1];
      frame_cnt   = frame_cnt_q;
      overflow    = overflow_q;
      short_frame = short_q;
   end

endmodule

// File: tb/tb_cam_capture_stream.sv
// Scoreboard bench for cam_capture_stream: a frame-level camera model queues expected beats,
// and a monitor pops and compares every accepted output beat.
module tb_cam_capture_stream;

   localparam int unsigned H  = 4;
   localparam int unsigned V  = 6;
   localparam int unsigned FD = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pclk, href, vsync, enable, clr_status;
   logic [7:0]  db;
   logic [15:0] out_data, frame_cnt;
   logic        out_valid, out_ready, out_sop, out_eop, overflow, short_frame;

   always #5 clk = ~clk;

   cam_capture_stream #(
      .DATA_W    (8),
      .PIX_BYTES (2),
      .H_ACTIVE  (H),
      .V_ACTIVE  (V),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk_clk      (clk),
      .reset_reset_n(rst_n),
      .cmos_pclk    (pclk),
      .cmos_href    (href),
      .cmos_vsync   (vsync),
      .cmos_db      (db),
      .enable       (enable),
      .out_data     (out_data),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sop      (out_sop),
      .out_eop      (out_eop),
      .frame_cnt    (frame_cnt),
      .overflow     (overflow),
      .short_frame  (short_frame),
      .clr_status   (clr_status)
   );

   typedef struct packed {
      logic [15:0] data;
      logic        sop;
      logic        eop;
   } beat_t;

   beat_t       exp_q[$];
   int          n_cmp = 0;
   int          n_err = 0;
   int          ready_mode = 0;  // 0: never ready, 1: always, 2: random
   logic [15:0] m_frames = '0;
   bit          m_ovf = 0, m_short = 0, m_open = 0;
   bit          seq_mode = 0;
   logic [7:0]  seq_byte = 8'h12;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] next_byte();
      logic [7:0] r;
      if (seq_mode) begin
         r = seq_byte;
         seq_byte = seq_byte + 8'h22;
      end else begin
         r = 8'($urandom);
      end
      return r;
   endfunction

   // Monitor: picks out_ready, scores accepted beats, checks stability under backpressure.
   bit    held = 0;
   beat_t held_b;

   always @(negedge clk) begin : mon
      beat_t cur, e;
      bit    r;
      cur.data = out_data;
      cur.sop  = out_sop;
      cur.eop  = out_eop;
      if (!rst_n) begin
         held      = 0;
         out_ready = 1'b0;
      end else begin
         if (held) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_beat", 32'(cur), 32'(held_b));
         end
         r = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(3) != 0);
         out_ready = r;
         held = 0;
         if (out_valid) begin
            if (r) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_beat: got data 0x%0h sop %0b eop %0b, expected none",
                           out_data, out_sop, out_eop);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", 32'(cur), 32'(e));
               end
            end else begin
               held   = 1;
               held_b = cur;
            end
         end
      end
   end

   // Drives one frame and predicts its beats. The model knows only frame/line/pixel indices,
   // the expected FIFO occupancy when the sink is stalled, and whether a frame is still open.
   task automatic send_frame(input int lines, input int lbytes, input int stop_pix,
                             input int odd_line, input bit hold);
      int         occ, tot, nbytes, x;
      bit         open, ovf, stop, keep, eop;
      logic [7:0] b0, b;
      beat_t      eb;
      vsync = 1'b1;
      wait_clk(8);
      if (m_open) begin
         m_short = 1;
         m_open  = 0;
      end
      vsync = 1'b0;
      open  = enable;
      ovf   = 0;
      occ   = 0;
      tot   = 0;
      stop  = 0;
      b0    = '0;
      wait_clk(8);
      for (int y = 0; y < lines && !stop; y++) begin
         nbytes = lbytes + ((y == odd_line) ? 1 : 0);
         href = 1'b1;
         wait_clk(2);
         for (int k = 0; k < nbytes && !stop; k++) begin
            b  = next_byte();
            db = b;
            wait_clk(4);
            pclk = 1'b1;
            if (k % 2 == 0) begin
               b0 = b;
            end else begin
               x    = k / 2;
               tot++;
               keep = (x < H) && (y < V);
               eop  = (x == H - 1) && (y == V - 1);
`ifdef CAM_DECIM_EN
               keep = keep && (x % 2 == 0) && (y % 2 == 0);
               eop  = (x == H - 2) && (y == V - 2);
`endif
               if (open && !ovf && keep) begin
                  if (hold && occ == FD) begin
                     ovf   = 1;
                     m_ovf = 1;
                  end else begin
                     eb.data = {b0, b};
                     eb.sop  = (x == 0) && (y == 0);
                     eb.eop  = eop;
                     exp_q.push_back(eb);
                     occ++;
                     if (eop) begin
                        open     = 0;
                        m_frames = m_frames + 16'd1;
                     end
                  end
               end
               if (stop_pix >= 0 && tot == stop_pix) stop = 1;
            end
            wait_clk(4);
            pclk = 1'b0;
         end
         href = 1'b0;
         wait_clk(8);
      end
      m_open = open && !ovf;
   endtask

   task automatic drain();
      int t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
         wait_clk(1);
         t++;
      end
      check("drain_pending", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_status(input string tag);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(m_frames));
      check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
      check({tag, "_short"}, 32'(short_frame), 32'(m_short));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, 32'(out_valid), 32'd0);
      check({tag, "_sop"}, 32'(out_sop), 32'd0);
      check({tag, "_eop"}, 32'(out_eop), 32'd0);
      check({tag, "_data"}, 32'(out_data), 32'd0);
      check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
      check({tag, "_overflow"}, 32'(overflow), 32'd0);
      check({tag, "_short"}, 32'(short_frame), 32'd0);
   endtask

   task automatic pulse_clr();
      clr_status = 1'b1;
      wait_clk(1);
      clr_status = 1'b0;
      wait_clk(1);
      m_ovf   = 0;
      m_short = 0;
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lines, lbytes, stop_pix, odd_line;
      pclk       = 1'b0;
      href       = 1'b0;
      vsync      = 1'b0;
      db         = '0;
      enable     = 1'b0;
      clr_status = 1'b0;

      // Reset with random camera activity: nothing may come out.
      enable = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         pclk  = 1'($urandom);
         href  = 1'($urandom);
         vsync = 1'($urandom);
         db    = 8'($urandom);
         if (i % 10 == 9) check_zero("reset");
      end
      pclk  = 1'b0;
      href  = 1'b0;
      vsync = 1'b0;
      enable = 1'b0;
      wait_clk(4);
      rst_n = 1'b1;
      wait_clk(4);
      check_zero("after_reset");

      // Disabled: a whole frame produces nothing.
      ready_mode = 1;
      send_frame(V, 2 * H, -1, -1, 0);
      drain();
      check_status("disabled");

      // Nominal frame with a known byte sequence.
      enable = 1'b1;
      wait_clk(4);
      seq_mode = 1;
      send_frame(V, 2 * H, -1, -1, 0);
      seq_mode = 0;
      drain();
      check_status("nominal");

      // Sink stalled for a whole frame: FIFO fills, overflow, rest dropped.
      ready_mode = 0;
      send_frame(V, 2 * H, -1, -1, 1);
      check_status("stalled");
      ready_mode = 1;
      drain();
      send_frame(V, 2 * H, -1, -1, 0);
      drain();
      check_status("after_stall");
      pulse_clr();
      check_status("clr_ovf");

      // Short frame: vsync arrives after 5 pixels.
      send_frame(V, 2 * H, 5, -1, 0);
      drain();
      check_status("short_pending");
      send_frame(V, 2 * H, -1, -1, 0);
      drain();
      check_status("short_seen");
      pulse_clr();
      check_status("clr_short");

      // Partial pixel at end of line 1, then excess pixels and lines.
      send_frame(V, 2 * H, -1, 1, 0);
      drain();
      check_status("partial");
      send_frame(V + 1, 2 * H + 4, -1, 2, 0);
      drain();
      check_status("excess");

      // Randomised frames with random backpressure.
      ready_mode = 2;
      for (int f = 0; f < 8; f++) begin
         lines    = int'($urandom_range(V + 1, V - 1));
         lbytes   = int'($urandom_range(2 * H + 3, 2 * H - 1));
         odd_line = int'($urandom_range(V, 0));
         stop_pix = ($urandom_range(3) == 0) ? int'($urandom_range(H * V - 1, 1)) : -1;
         send_frame(lines, lbytes, stop_pix, odd_line, 0);
         drain();
         check_status("random");
         if (f % 3 == 2) begin
            pulse_clr();
            check_status("random_clr");
         end
      end

      // Reset with a full FIFO clears everything; capture resumes afterwards.
      ready_mode = 0;
      send_frame(V, 2 * H, -1, -1, 1);
      wait_clk(2);
      rst_n = 1'b0;
      exp_q.delete();
      m_frames = '0;
      m_ovf    = 0;
      m_short  = 0;
      m_open   = 0;
      wait_clk(3);
      check_zero("mid_reset");
      rst_n = 1'b1;
      wait_clk(4);
      check_zero("post_reset");
      ready_mode = 1;
      send_frame(V, 2 * H, -1, -1, 0);
      drain();
      check_status("restart");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
